// File: rtl/feature_vector_loader.sv
// Assembles N_INPUTS signed 16-bit stream samples into one vector held stable for a parallel consumer.
// Latency: final beat accepted at edge t -> o_vec_valid high from edge t+1; err_len one cycle after a violation.
// Backpressure: o_s_ready drops while a completed vector has nowhere to go (HOLD, or FULL with FEATURE_LOADER_DOUBLE_BUFFER_EN).
module feature_vector_loader #(
   parameter int N_INPUTS = 4,
   parameter int CNT_W    = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic signed [15:0]         i_s_data,
   input  logic                       i_s_valid,
   input  logic                       i_s_last,
   output logic                       o_s_ready,
   output logic [N_INPUTS-1:0][15:0]  o_vec_out,
   output logic                       o_vec_valid,
   input  logic                       i_vec_ready,
   output logic                       o_err_len,
   output logic [CNT_W-1:0]           o_vec_cnt
);

   localparam int IDX_W = $clog2(N_INPUTS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

   typedef enum logic [1:0] {ST_FILL, ST_FULL, ST_HOLD} state_t;

   state_t                      r_state;
   logic [IDX_W-1:0]            r_idx;
   logic [N_INPUTS-1:0][15:0]   r_fill;
   logic                        r_vec_valid;
   logic                        r_err_len;
   logic [CNT_W-1:0]            r_vec_cnt;
`ifdef FEATURE_LOADER_DOUBLE_BUFFER_EN
   logic [N_INPUTS-1:0][15:0]   r_out;
`endif

   logic                        w_accept;
   logic                        w_handoff;
   logic                        w_at_last;
   logic [N_INPUTS-1:0][15:0]   w_fill_nxt;

   // Ready depends only on the registered state (and reset), never on i_s_valid.
   // In double-buffer mode the FSM never visits HOLD, so "in FILL" covers both modes.
   assign o_s_ready   = !i_rst && (r_state == ST_FILL);
   assign w_accept    = i_s_valid && o_s_ready;
   assign w_handoff   = r_vec_valid && i_vec_ready;
   assign w_at_last   = (r_idx == LAST_IDX);

   assign o_vec_valid = r_vec_valid;
   assign o_err_len   = r_err_len;
   assign o_vec_cnt   = r_vec_cnt;
`ifdef FEATURE_LOADER_DOUBLE_BUFFER_EN
   assign o_vec_out   = r_out;
`else
   assign o_vec_out   = r_fill;
`endif

   // Fill buffer as it will look after this cycle's beat, so a completing beat can move straight to the output.
   always_comb begin
      w_fill_nxt = r_fill;
      if (w_accept) begin
         w_fill_nxt[r_idx] = i_s_data;
      end
   end

   // Fill FSM, fill index, output register, length-error pulse and handoff counter.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_FILL;
         r_idx       <= '0;
         r_fill      <= '0;
         r_vec_valid <= 1'b0;
         r_err_len   <= 1'b0;
         r_vec_cnt   <= '0;
`ifdef FEATURE_LOADER_DOUBLE_BUFFER_EN
         r_out       <= '0;
`endif
      end else begin
         r_err_len <= 1'b0;
         if (w_handoff) begin
            r_vec_cnt <= r_vec_cnt + CNT_W'(1);
         end
         if (w_accept) begin
            r_fill <= w_fill_nxt;
         end
         case (r_state)
            ST_FILL: begin
`ifdef FEATURE_LOADER_DOUBLE_BUFFER_EN
               if (w_handoff) begin
                  r_vec_valid <= 1'b0;
               end
`endif
               if (w_accept) begin
                  if (w_at_last) begin
                     // Vector complete; a missing end marker still delivers but flags the length.
                     r_idx     <= '0;
                     r_err_len <= !i_s_last;
`ifdef FEATURE_LOADER_DOUBLE_BUFFER_EN
                     if (!r_vec_valid || w_handoff) begin
                        r_out       <= w_fill_nxt;
                        r_vec_valid <= 1'b1;
                     end else begin
                        r_state <= ST_FULL;
                     end
`else
                     r_vec_valid <= 1'b1;
                     r_state     <= ST_HOLD;
`endif
                  end else if (i_s_last) begin
                     // Short frame: drop what was collected and start over.
                     r_idx     <= '0;
                     r_err_len <= 1'b1;
                  end else begin
                     r_idx <= r_idx + IDX_W'(1);
                  end
               end
            end
`ifdef FEATURE_LOADER_DOUBLE_BUFFER_EN
            ST_FULL: begin
               // Output is taken this cycle: refill it from the waiting buffer, valid stays high.
               if (w_handoff) begin
                  r_out   <= r_fill;
                  r_state <= ST_FILL;
               end
            end
`endif
            ST_HOLD: begin
               if (w_handoff) begin
                  r_vec_valid <= 1'b0;
                  r_state     <= ST_FILL;
               end
            end
            default: begin
               r_state <= ST_FILL;
            end
         endcase
      end
   end

endmodule

// File: doc/feature_vector_loader.md
# feature_vector_loader

Streaming front-end for the inference datapath. It accepts signed 16-bit feature samples one per beat over a valid/ready stream and assembles them into a complete N_INPUTS-element vector. It holds that vector stable on a parallel array output with a valid/ready handshake, so the combinational dense layer downstream always sees a coherent vector. It also checks frame length against an end-of-frame marker and counts delivered vectors.

## Interface
- N_INPUTS, 4: elements per vector; must be ≥ 2.
- CNT_W, 16: width of the delivered-vector counter.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  signed [15:0]  feature sample.
- s_valid  in  1  sample valid.
- s_last  in  1  marks the final sample of a frame; qualified by s_valid.
- s_ready  out  1  loader can accept a sample this cycle.
- vec_out  out  signed [15:0] [N_INPUTS]  assembled vector; element i is the i-th accepted sample of the frame.
- vec_valid  out  1  vec_out holds a complete vector.
- vec_ready  in  1  consumer accepts vec_out.
- err_len  out  1  one-cycle pulse on a frame-length violation.
- vec_cnt  out  [CNT_W-1:0]  number of vectors handed off; wraps modulo 2^CNT_W.

## Operation
- A beat is accepted when s_valid && s_ready. A handoff occurs when vec_valid && vec_ready.
- Fill index idx runs 0..N_INPUTS-1.
  - Each accepted beat writes s_data into fill element idx.
  - idx increments on each accepted beat.
  - idx returns to 0 on the N_INPUTS-th beat or on an early s_last.
- Fill FSM states:
  - FILL: accepting beats.
  - FULL: vector complete, waiting for the output register to free. Only reachable with DOUBLE_BUFFER_EN.
  - HOLD: single-buffer mode, waiting for handoff.
- Normal frame: the beat at idx = N_INPUTS-1 with s_last = 1 completes the vector.
- Early s_last (idx < N_INPUTS-1):
  - The partial frame is discarded and idx returns to 0.
  - err_len pulses on the next cycle.
  - No vector is produced.
- Missing s_last on the beat at idx = N_INPUTS-1:
  - The vector is still completed and delivered.
  - err_len pulses on the next cycle.
- vec_out changes only when vec_valid is low or in the cycle following a handoff. It is never altered while vec_valid is high.
- vec_cnt increments by 1 on every handoff.
- Arithmetic: samples pass through unmodified. No scaling or saturation.

## Timing
- Reset values: s_ready = 0 while rst is high; vec_valid = 0; err_len = 0; vec_cnt = 0; vec_out elements = 0; idx = 0; state FILL.
- First cycle after rst deasserts: s_ready = 1.
- Latency: final beat accepted at edge t → vec_valid = 1 from edge t+1.
- vec_valid stays high until the edge at which vec_ready is sampled high.
- err_len is registered: violation at edge t → err_len = 1 for exactly the cycle after t.
- rst asserted mid-frame or mid-hold:
  - The partial frame and any held vector are dropped.
  - All outputs return to their reset values at the next edge.
- s_ready is a function of registered state only. It never depends combinationally on s_valid.

## Configuration
- Macro `FEATURE_LOADER_DOUBLE_BUFFER_EN`.
- Defined: separate fill buffer and output register.
  - On completion, the fill contents move to the output register at the next edge if the output is empty or a handoff occurs that same cycle; otherwise the FSM enters FULL.
  - s_ready = 0 only in FULL.
  - FULL exits at the edge of the next handoff: the fill buffer transfers and s_ready = 1 the following cycle.
  - Back-to-back frames with vec_ready held high sustain one sample per cycle.
- Undefined: the fill buffer drives vec_out directly.
  - After completion the FSM enters HOLD with s_ready = 0.
  - On handoff it returns to FILL, with s_ready = 1 in the next cycle.
  - Throughput is N_INPUTS beats plus at least one handoff cycle per vector.

## Test plan
- Reset, then send 1,2,3,4 (s_last on 4th) with vec_ready=1 → vec_out = {1,2,3,4} and vec_valid high the cycle after beat 4; vec_cnt = 1; err_len never pulses.
- Send −5,7,s_last on 7 → err_len one-cycle pulse, vec_valid stays 0; next frame 10,20,30,40 delivers {10,20,30,40}.
- Send 4 beats with s_last=0 on all → vector delivered and err_len pulses once.
- vec_ready=0 for 10 cycles after a frame completes → vec_out is constant. Single-buffer mode: s_ready = 0 throughout. Double-buffer mode: the next 4 beats are accepted, then s_ready = 0 until the handoff.
- Double-buffer mode, 3 continuous frames with vec_ready=1, s_valid=1 → s_ready never drops; vec_cnt = 3.
- Assert rst after 2 beats of a frame → vec_valid = 0, vec_cnt = 0, vec_out all 0; the next full frame is delivered correctly.
